// File: rtl/lcd_sched_pkg.sv
// Shared definitions for the lcd_ctrl command scheduler.
package lcd_sched_pkg;

    localparam int IMG_BYTES = 36;
    localparam int WIN_PIX   = 9;

    typedef enum logic [2:0] {
        CMD_REFRESH = 3'd0,
        CMD_LOAD    = 3'd1,
        CMD_RIGHT   = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_UP      = 3'd4,
        CMD_DOWN    = 3'd5
    } lcd_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_WAITI = 3'd4
    } sched_state_e;

    // Codes 6 and 7 have no meaning to lcd_ctrl and are discarded.
    function automatic logic cmd_is_illegal(input logic [2:0] cmd);
        return (cmd == 3'd6) || (cmd == 3'd7);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Per-requester 3-bit command FIFO. req_ready is registered so that it is
// low throughout reset and rises the cycle after reset releases.
module lcd_cmd_fifo
    import lcd_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [2:0] i_din,
    input  logic       i_pop,
    output logic [2:0] o_dout,
    output logic       o_empty,
    output logic       o_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [AW:0]   w_cnt_next;

    assign w_push     = i_push && r_ready;
    assign w_pop      = i_pop && (r_cnt != '0);
    assign w_cnt_next = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign o_dout     = r_mem[r_rd];
    assign o_empty    = (r_cnt == '0);
    assign o_ready    = r_ready;

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers, occupancy and registered not-full flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt   <= w_cnt_next;
            r_ready <= (w_cnt_next != FULL_CNT);
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Round-robin scheduler sharing one lcd_ctrl between NREQ command sources.
// Optional: define SCHED_TIMEOUT_EN to abort a command whose lcd_ctrl
// response takes longer than TIMEOUT cycles from issue.
//
//  state   | meaning
//  IDLE    | wait for a queued command and lcd_busy low, pop winner
//  ISSUE   | lcd_cmd_valid high for one cycle
//  LOAD    | stream image bytes 0..35 to lcd_ctrl
//  DRAIN   | forward 9 window pixels
//  WAITI   | wait for lcd_busy low, then pulse done
module lcd_cmd_sched
    import lcd_sched_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_cmd,
    output logic [NREQ-1:0]   req_ready,
    output logic [5:0]        img_addr,
    input  logic [7:0]        img_data,
    output logic [2:0]        lcd_cmd,
    output logic              lcd_cmd_valid,
    output logic [7:0]        lcd_datain,
    input  logic              lcd_busy,
    input  logic [7:0]        lcd_dout,
    input  logic              lcd_dvalid,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic [1:0]        pix_id,
    output logic              done,
    output logic              cmd_err
);

    sched_state_e  r_state;
    logic [1:0]    r_rr;
    logic [5:0]    r_img_addr;
    logic [3:0]    r_beat;
    logic [2:0]    r_lcd_cmd;
    logic          r_lcd_cmd_valid;
    logic          r_pix_valid;
    logic [7:0]    r_pix_data;
    logic [1:0]    r_pix_id;
    logic          r_done;
    logic          r_err;

    logic [2:0]      w_fifo_dout [NREQ];
    logic [NREQ-1:0] w_empty;
    logic [NREQ-1:0] w_pop;
    logic            w_any;
    logic [1:0]      w_win;
    logic [2:0]      w_sel_cmd;
    logic            w_start;
    logic            w_tmo_hit;
    int              w_dist;
    int              w_best;

    for (genvar g = 0; g < NREQ; g++) begin : g_fifo
        lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (req_valid[g]),
            .i_din   (req_cmd[3*g +: 3]),
            .i_pop   (w_pop[g]),
            .o_dout  (w_fifo_dout[g]),
            .o_empty (w_empty[g]),
            .o_ready (req_ready[g])
        );
    end

    // Round-robin pick: non-empty FIFO closest to the pointer, counting upward.
    always_comb begin
        w_any     = 1'b0;
        w_win     = '0;
        w_sel_cmd = '0;
        w_best    = NREQ;
        w_dist    = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i >= int'(r_rr)) ? i - int'(r_rr) : i + NREQ - int'(r_rr);
            if (!w_empty[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_win     = 2'(i);
                w_sel_cmd = w_fifo_dout[i];
                w_any     = 1'b1;
            end
        end
    end

    assign w_start = (r_state == S_IDLE) && w_any && !lcd_busy;

    // Pop strobe to the winning FIFO only.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pop[i] = w_start && (w_win == 2'(i));
        end
    end

`ifdef SCHED_TIMEOUT_EN
    logic [7:0] r_tmo;

    // Cycles since ISSUE; held at zero while idle, saturates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if (r_state == S_IDLE) begin
            r_tmo <= '0;
        end else if (r_tmo != 8'hFF) begin
            r_tmo <= r_tmo + 8'd1;
        end
    end

    assign w_tmo_hit = ((r_state == S_LOAD) || (r_state == S_DRAIN) || (r_state == S_WAITI))
                       && (r_tmo == 8'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_rr            <= '0;
            r_img_addr      <= '0;
            r_beat          <= '0;
            r_lcd_cmd       <= '0;
            r_lcd_cmd_valid <= 1'b0;
            r_pix_valid     <= 1'b0;
            r_pix_data      <= '0;
            r_pix_id        <= '0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_lcd_cmd_valid <= 1'b0;
            r_pix_valid     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rr     <= (w_win == 2'(NREQ - 1)) ? 2'd0 : w_win + 2'd1;
                        r_pix_id <= w_win;
                        if (cmd_is_illegal(w_sel_cmd)) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else begin
                            r_lcd_cmd       <= w_sel_cmd;
                            r_lcd_cmd_valid <= 1'b1;
                            r_beat          <= '0;
                            r_state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_img_addr <= '0;
                    r_state    <= (r_lcd_cmd == CMD_LOAD) ? S_LOAD : S_DRAIN;
                end
                S_LOAD: begin
                    if (r_img_addr == 6'(IMG_BYTES - 1)) begin
                        r_img_addr <= '0;
                        r_state    <= S_DRAIN;
                    end else begin
                        r_img_addr <= r_img_addr + 6'd1;
                    end
                end
                S_DRAIN: begin
                    if (lcd_dvalid) begin
                        r_pix_valid <= 1'b1;
                        r_pix_data  <= lcd_dout;
                        if (r_beat == 4'(WIN_PIX - 1)) begin
                            r_state <= S_WAITI;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                        end
                    end
                end
                S_WAITI: begin
                    if (!lcd_busy) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_tmo_hit) begin
                r_done     <= 1'b1;
                r_err      <= 1'b1;
                r_img_addr <= '0;
                r_state    <= S_IDLE;
            end
        end
    end

    assign img_addr      = r_img_addr;
    assign lcd_datain    = img_data;
    assign lcd_cmd       = r_lcd_cmd;
    assign lcd_cmd_valid = r_lcd_cmd_valid;
    assign pix_valid     = r_pix_valid;
    assign pix_data      = r_pix_data;
    assign pix_id        = r_pix_id;
    assign done          = r_done;
    assign cmd_err       = r_err;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Scoreboard bench for lcd_cmd_sched with a behavioural lcd_ctrl stand-in.
module tb_lcd_cmd_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [5:0] req_cmd;
    wire  [1:0] req_ready;
    wire  [5:0] img_addr;
    wire  [7:0] img_data;
    wire  [2:0] lcd_cmd;
    wire        lcd_cmd_valid;
    wire  [7:0] lcd_datain;
    wire        lcd_busy;
    logic [7:0] lcd_dout;
    logic       lcd_dvalid;
    wire        pix_valid;
    wire  [7:0] pix_data;
    wire  [1:0] pix_id;
    wire        done;
    wire        cmd_err;

    logic       stub_busy = 1'b0;
    logic       hold_busy = 1'b0;
    logic       abandon   = 1'b0;
    logic [7:0] rom [36];

    int n_vec = 0;
    int n_bad = 0;
    int n_issue = 0;
    int n_cv = 0;

    logic [2:0] q0 [$];
    logic [2:0] q1 [$];
    int         order [$];
    int         last_pix [9];

    // reference lcd state
    logic [7:0] m_img [36];
    int         m_row = 2;
    int         m_col = 2;
    // stand-in lcd_ctrl state
    logic [7:0] s_img [36];
    int         s_row = 2;
    int         s_col = 2;

    always #5 clk = ~clk;

    assign img_data = (img_addr < 6'd36) ? rom[img_addr] : 8'h00;
    assign lcd_busy = stub_busy | hold_busy;

    lcd_cmd_sched #(.NREQ(2), .FIFO_DEPTH(4), .TIMEOUT(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .img_addr      (img_addr),
        .img_data      (img_data),
        .lcd_cmd       (lcd_cmd),
        .lcd_cmd_valid (lcd_cmd_valid),
        .lcd_datain    (lcd_datain),
        .lcd_busy      (lcd_busy),
        .lcd_dout      (lcd_dout),
        .lcd_dvalid    (lcd_dvalid),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_id        (pix_id),
        .done          (done),
        .cmd_err       (cmd_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int win_index(input int row, input int col, input int n);
        return (row + n / 3) * 6 + col + n % 3;
    endfunction

    task automatic q_push(input int id, input logic [2:0] c);
        if (id == 0) q0.push_back(c);
        else         q1.push_back(c);
    endtask

    // lcd_ctrl stand-in: serves one command after seeing cmd_valid.
    task automatic stub_serve(input logic [2:0] c);
        logic [7:0] tmp [36];
        int gap;
        stub_busy = 1'b1;
        if (c == 3'd1) begin
            for (int k = 0; k < 36; k++) begin
                @(negedge clk);
                if (abandon) begin
                    stub_busy = 1'b0;
                    return;
                end
                chk("img_addr_seq", int'(img_addr), k);
                tmp[k] = lcd_datain;
            end
            s_img = tmp;
            s_row = 2;
            s_col = 2;
        end else begin
            case (c)
                3'd2: s_col = (s_col + 1 > 3) ? 3 : s_col + 1;
                3'd3: s_col = (s_col - 1 < 0) ? 0 : s_col - 1;
                3'd4: s_row = (s_row - 1 < 0) ? 0 : s_row - 1;
                3'd5: s_row = (s_row + 1 > 3) ? 3 : s_row + 1;
                default: ;
            endcase
        end
        for (int b = 0; b < 9; b++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                lcd_dvalid = 1'b0;
                if (abandon) begin
                    stub_busy = 1'b0;
                    return;
                end
            end
            lcd_dvalid = 1'b1;
            lcd_dout   = s_img[win_index(s_row, s_col, b)];
        end
        @(negedge clk);
        lcd_dvalid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        stub_busy = 1'b0;
    endtask

    initial begin
        lcd_dvalid = 1'b0;
        lcd_dout   = 8'h00;
        forever begin
            @(negedge clk);
            if (reset && lcd_cmd_valid && !abandon) begin
                n_issue++;
                stub_serve(lcd_cmd);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && lcd_cmd_valid) n_cv++;
        end
    end

    // Scoreboard monitor: collects pixel beats, checks them on done.
    initial begin
        int beats [$];
        int bids [$];
        int id;
        logic [2:0] c;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                beats.delete();
                bids.delete();
            end else begin
                if (pix_valid) begin
                    beats.push_back(int'(pix_data));
                    bids.push_back(int'(pix_id));
                end
                if (cmd_err && !done) chk("err_without_done", 1, 0);
                if (done) begin
                    id = int'(pix_id);
                    order.push_back(id);
                    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0) || id > 1) begin
                        chk("done_unexpected_id", id, -1);
                    end else begin
                        c = (id == 0) ? q0.pop_front() : q1.pop_front();
                        chk("cmd_err", int'(cmd_err), (c > 3'd5) ? 1 : 0);
                        if (c <= 3'd5) begin
                            if (c == 3'd1) begin
                                for (int k = 0; k < 36; k++) m_img[k] = rom[k];
                                m_row = 2;
                                m_col = 2;
                            end else if (c == 3'd2 && m_col < 3) m_col++;
                            else if (c == 3'd3 && m_col > 0) m_col--;
                            else if (c == 3'd4 && m_row > 0) m_row--;
                            else if (c == 3'd5 && m_row < 3) m_row++;
                            chk("beat_count", beats.size(), 9);
                            for (int n = 0; n < 9 && n < beats.size(); n++) begin
                                chk("pix_data", beats[n], int'(m_img[win_index(m_row, m_col, n)]));
                                chk("pix_id_beat", bids[n], id);
                                last_pix[n] = beats[n];
                            end
                        end else begin
                            chk("beat_count_discard", beats.size(), 0);
                        end
                    end
                    beats.delete();
                    bids.delete();
                end
            end
        end
    end

    task automatic push1(input int id, input logic [2:0] c);
        req_valid[id]       = 1'b1;
        req_cmd[3*id +: 3]  = c;
        if (req_ready[id]) q_push(id, c);
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_queues", q0.size() + q1.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [2:0] rnd_cmd();
        int r;
        r = $urandom_range(0, 15);
        if (r < 2) return 3'd1;
        if (r == 2) return 3'd6;
        if (r == 3) return 3'd7;
        if (r < 6) return 3'd0;
        return 3'($urandom_range(2, 5));
    endfunction

    initial begin
        int exp_win [9];
        int acc;
        logic [2:0] c;
        exp_win = '{14, 15, 16, 20, 21, 22, 26, 27, 28};
        reset     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        for (int k = 0; k < 36; k++) begin
            rom[k]   = 8'(k);
            m_img[k] = 8'h00;
            s_img[k] = 8'h00;
        end

        // reset held low for three clock edges
        repeat (3) @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_img_addr", int'(img_addr), 0);
        chk("rst_lcd_cmd", int'(lcd_cmd), 0);
        chk("rst_cmd_valid", int'(lcd_cmd_valid), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_pix_id", int'(pix_id), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("datain_follows_rom", int'(lcd_datain), int'(rom[0]));
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", int'(req_ready), 3);

        // LOAD from requester 0 with ROM byte k = k
        push1(0, 3'd1);
        wait_idle(400);
        for (int n = 0; n < 9; n++) chk("load_window", last_pix[n], exp_win[n]);
        chk("load_owner", order[order.size()-1], 0);

        // discarded command: done+cmd_err one cycle after the pop
        push1(1, 3'd7);
        chk("bad_cmd_no_done_yet", int'(done), 0);
        @(negedge clk);
        chk("bad_cmd_done", int'(done), 1);
        chk("bad_cmd_err", int'(cmd_err), 1);
        chk("bad_cmd_id", int'(pix_id), 1);
        wait_idle(20);

        // simultaneous requests: issue order 0,1,0
        order.delete();
        req_valid = 2'b11;
        req_cmd   = {3'd4, 3'd2};
        if (req_ready[0]) q_push(0, 3'd2);
        if (req_ready[1]) q_push(1, 3'd4);
        @(negedge clk);
        req_valid = 2'b01;
        req_cmd   = {3'd0, 3'd2};
        if (req_ready[0]) q_push(0, 3'd2);
        @(negedge clk);
        req_valid = 2'b00;
        wait_idle(600);
        chk("rr_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("rr_first", order[0], 0);
            chk("rr_second", order[1], 1);
            chk("rr_third", order[2], 0);
        end

        // fill requester 1 while lcd_ctrl is held busy
        hold_busy = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            req_valid[1] = 1'b1;
            req_cmd[5:3] = 3'd0;
            chk("full_ready", int'(req_ready[1]), (i < 4) ? 1 : 0);
            if (req_ready[1]) begin
                q_push(1, 3'd0);
                acc++;
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        chk("full_accepted", acc, 4);
        repeat (5) @(negedge clk);
        chk("busy_blocks_issue", order.size(), 3);
        hold_busy = 1'b0;
        wait_idle(1000);

        // randomized traffic with a fresh random image
        for (int k = 0; k < 36; k++) rom[k] = 8'($urandom_range(0, 255));
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int id = 0; id < 2; id++) begin
                if ($urandom_range(0, 9) == 0) begin
                    c = rnd_cmd();
                    req_valid[id]      = 1'b1;
                    req_cmd[3*id +: 3] = c;
                    if (req_ready[id]) q_push(id, c);
                end else begin
                    req_valid[id] = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        wait_idle(20000);

        // reset in the middle of a LOAD abandons it
        push1(0, 3'd1);
        for (int i = 0; i < 200; i++) begin
            if (img_addr == 6'd10) break;
            @(negedge clk);
        end
        chk("midload_reached", int'(img_addr), 10);
        abandon = 1'b1;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_img_addr", int'(img_addr), 0);
        chk("midrst_cmd_valid", int'(lcd_cmd_valid), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_ready", int'(req_ready), 0);
        q0.delete();
        q1.delete();
        reset = 1'b1;
        @(negedge clk);
        abandon = 1'b0;
        chk("midrst_ready_back", int'(req_ready), 3);
        push1(1, 3'd0);
        push1(0, 3'd6);
        wait_idle(400);

        chk("cmd_valid_only_in_issue", n_cv, n_issue);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
